// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM-stage access controller: FSM encoding,
// access size codes and the data value reported on a failed access.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0]  SZ_BYTE      = 2'b00;
  localparam logic [1:0]  SZ_HALF      = 2'b01;
  localparam logic [1:0]  SZ_WORD      = 2'b10;
  localparam logic [31:0] MEM_ERR_DATA = 32'hDEADBEEF;

  // Memory is word addressed: the byte offset never reaches the bus.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane handling for sub-word accesses (used only when MEM_SUBWORD_EN
// is defined): byte enables and store-lane replication from the current
// request, load extraction and sign/zero extension from the latched request.
module mem_lane_align
  import pipeline_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic        misaligned,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: lane enables, replicated data, alignment check.
  always_comb begin
    be         = 4'hF;
    lane_data  = st_data;
    misaligned = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        be        = 4'b0001 << st_off;
        lane_data = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        be         = st_off[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{st_data[15:0]}};
        misaligned = st_off[0];
      end
      default: misaligned = |st_off;
    endcase
  end

  // Load side: pick the addressed lane and extend to 32 bits.
  always_comb begin
    ld_byte = rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: passes non-memory instructions to MEM/WB in one
// cycle, runs a req/ack data-memory access for loads/stores while stalling
// the upstream pipe, and aborts an access that is not acked in MAX_WAIT
// BUSY cycles. Optional macro MEM_SUBWORD_EN adds byte/half accesses.
// Memory handshake: mem_req rises with address/data/byte enables and stays
// high until the cycle in which mem_ack (a one-cycle pulse) is seen or the
// access times out; mem_ack outside BUSY is ignored.
module mem_access_ctrl
  import pipeline_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  WBin,
  input  logic [1:0]  MEMin,
  input  logic [31:0] ALUin,
  input  logic [31:0] WDin,
  input  logic [4:0]  WNin,
  output logic [1:0]  WBout,
  output logic [31:0] DMout,
  output logic [31:0] ADDRout,
  output logic [4:0]  WNout,
  output logic        wb_enable,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err,
`ifdef MEM_SUBWORD_EN
  input  logic [1:0]  SIZEin,
  input  logic [0:0]  UNSIGNEDin,
`endif
  output logic [1:0]  fsm_state
);

  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_t      state, next_state;
  logic        access, timeout;
  logic [1:0]  lat_wb;
  logic [31:0] lat_addr, lat_data;
  logic [4:0]  lat_wn;
  logic        lat_rd;
  logic [7:0]  cnt;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_data;
  logic        misaligned;

  assign access    = MEMin[1] | MEMin[0];
  assign timeout   = (cnt == LAST_CNT);
  assign fsm_state = state;

`ifdef MEM_SUBWORD_EN
  logic [1:0] lat_size;
  logic       lat_uns;

  mem_lane_align u_align (
    .st_size     (SIZEin),
    .st_off      (ALUin[1:0]),
    .st_data     (WDin),
    .be          (st_be),
    .lane_data   (st_data),
    .misaligned  (misaligned),
    .ld_size     (lat_size),
    .ld_off      (lat_addr[1:0]),
    .ld_unsigned (lat_uns),
    .rdata       (mem_rdata),
    .ld_data     (ld_data)
  );

  // Remember size/sign of the access for load extraction in BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_size <= SZ_BYTE;
      lat_uns  <= 1'b0;
    end else if (state == ST_IDLE && access) begin
      lat_size <= SIZEin;
      lat_uns  <= UNSIGNEDin[0];
    end
  end
`else
  assign st_be      = 4'hF;
  assign st_data    = WDin;
  assign misaligned = 1'b0;
  assign ld_data    = mem_rdata;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next state: misaligned accesses skip the bus; DONE lasts one cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (access) next_state = misaligned ? ST_DONE : ST_BUSY;
      ST_BUSY: if (mem_ack || timeout) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Access datapath: latch the instruction, drive the bus, capture the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      err       <= 1'b0;
      lat_wb    <= '0;
      lat_addr  <= '0;
      lat_wn    <= '0;
      lat_rd    <= 1'b0;
      lat_data  <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            lat_wb   <= WBin;
            lat_addr <= ALUin;
            lat_wn   <= WNin;
            lat_rd   <= MEMin[1];
            cnt      <= '0;
            if (misaligned) begin
              err      <= 1'b1;
              lat_data <= MEM_ERR_DATA;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= ~MEMin[1];
              mem_addr  <= word_addr(ALUin);
              mem_wdata <= st_data;
              mem_be    <= st_be;
              lat_data  <= '0;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt + 8'd1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (lat_rd) lat_data <= ld_data;
          end else if (timeout) begin
            mem_req  <= 1'b0;
            err      <= 1'b1;
            lat_data <= MEM_ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: IDLE passes the current instruction, DONE presents the latched one.
  always_comb begin
    wb_enable = 1'b0;
    stall     = 1'b0;
    WBout     = lat_wb;
    ADDRout   = lat_addr;
    WNout     = lat_wn;
    DMout     = lat_data;
    case (state)
      ST_IDLE: begin
        wb_enable = ~access;
        stall     = access;
        WBout     = WBin;
        ADDRout   = ALUin;
        WNout     = WNin;
        DMout     = '0;
      end
      ST_BUSY: stall = 1'b1;
      ST_DONE: wb_enable = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized bench for mem_access_ctrl with a memory responder
// that acks after a chosen number of BUSY cycles. Expected stall length,
// load data and error flag come from a transaction-level model.
module tb_mem_access_ctrl;
  import pipeline_pkg::*;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  WBin, MEMin;
  logic [31:0] ALUin, WDin;
  logic [4:0]  WNin;
  logic [1:0]  WBout;
  logic [31:0] DMout, ADDRout;
  logic [4:0]  WNout;
  logic        wb_enable, stall, mem_req, mem_we, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [1:0]  fsm_state;
  logic [1:0]  size_v = 2'b10;
  logic        uns_v  = 1'b0;

  int   checks   = 0;
  int   failures = 0;
  logic exp_err  = 1'b0;

  mem_access_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .WBin(WBin), .MEMin(MEMin), .ALUin(ALUin),
    .WDin(WDin), .WNin(WNin), .WBout(WBout), .DMout(DMout), .ADDRout(ADDRout),
    .WNout(WNout), .wb_enable(wb_enable), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err),
`ifdef MEM_SUBWORD_EN
    .SIZEin(size_v), .UNSIGNEDin(uns_v),
`endif
    .fsm_state(fsm_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules for sub-word accesses; plain word behaviour otherwise.
  function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_SUBWORD_EN
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_SUBWORD_EN
    if (sz == 2'b00) return 4'(1 << a[1:0]);
    if (sz == 2'b01) return 4'(3 << a[1:0]);
`endif
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
`ifdef MEM_SUBWORD_EN
    if (sz == 2'b00) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
`endif
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a,
                                           input logic u, input logic [31:0] rd);
    logic [31:0] v;
    v = rd;
`ifdef MEM_SUBWORD_EN
    if (sz == 2'b00) begin
      v = (rd >> (8 * a[1:0])) & 32'hFF;
      if (!u && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = (rd >> (8 * a[1:0])) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v + 32'hFFFF0000;
    end
`endif
    return v;
  endfunction

  // Issue one instruction (called just after a posedge) and follow it to MEM/WB.
  // k = BUSY cycle in which the memory acks.
  task automatic run_instr(input string tag, input logic [1:0] wb, input logic [1:0] mem,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] wn, input int k, input logic [31:0] rd);
    logic        acc, mis, done;
    int          exp_stall, stall_cnt;
    logic [31:0] exp_dm;
    acc = |mem;
    mis = acc && ref_mis(size_v, alu);
    if (!acc)               exp_stall = 0;
    else if (mis)           exp_stall = 1;
    else if (k <= MAX_WAIT) exp_stall = k + 1;
    else                    exp_stall = MAX_WAIT + 1;
    if (!acc)               exp_dm = 32'h0;
    else if (mis || k > MAX_WAIT) exp_dm = 32'hDEADBEEF;
    else if (mem[1])        exp_dm = ref_load(size_v, alu, uns_v, rd);
    else                    exp_dm = 32'h0;
    if (acc && (mis || k > MAX_WAIT)) exp_err = 1'b1;
    WBin = wb; MEMin = mem; ALUin = alu; WDin = wd; WNin = wn;
    mem_rdata = rd;
    done = 1'b0;
    stall_cnt = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_ack = acc && (c == k);
      @(negedge clk);
      if (acc && c == 1) begin
        chk({tag, ".req"}, 32'(mem_req), 32'(!mis));
        if (!mis) begin
          chk({tag, ".we"}, 32'(mem_we), 32'(!mem[1]));
          chk({tag, ".addr"}, mem_addr, alu & 32'hFFFFFFFC);
          chk({tag, ".be"}, 32'(mem_be), 32'(ref_be(size_v, alu)));
          if (!mem[1]) chk({tag, ".wdata"}, mem_wdata, ref_wdata(size_v, wd));
        end
      end
      if (wb_enable) begin
        done = 1'b1;
        chk({tag, ".stall_done"}, 32'(stall), 32'h0);
        chk({tag, ".wb"}, 32'(WBout), 32'(wb));
        chk({tag, ".addrout"}, ADDRout, alu);
        chk({tag, ".wn"}, 32'(WNout), 32'(wn));
        chk({tag, ".dm"}, DMout, exp_dm);
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        chk({tag, ".req_done"}, 32'(mem_req), 32'h0);
      end else begin
        stall_cnt += int'(stall);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    chk({tag, ".completed"}, 32'(done), 32'h1);
    chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
  endtask

  initial begin
    logic [1:0] rop;
    // Reset block.
    reset = 1'b1; WBin = '0; MEMin = '0; ALUin = '0; WDin = '0; WNin = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.state", 32'(fsm_state), 32'(ST_IDLE));
    chk("rst.req", 32'(mem_req), 32'h0);
    chk("rst.addr", mem_addr, 32'h0);
    chk("rst.be", 32'(mem_be), 32'h0);
    chk("rst.err", 32'(err), 32'h0);
    chk("rst.wben", 32'(wb_enable), 32'h1);
    chk("rst.stall", 32'(stall), 32'h0);
    @(posedge clk); #1;

    // Directed cases.
    run_instr("nop",      2'b10, 2'b00, 32'h10, 32'h0,        5'd5,  1,  32'h0);
    run_instr("load_k3",  2'b11, 2'b10, 32'h40, 32'h0,        5'd7,  3,  32'hCAFEF00D);
    run_instr("store_k1", 2'b00, 2'b01, 32'h44, 32'h12345678, 5'd0,  1,  32'h55555555);
    run_instr("both_rd",  2'b01, 2'b11, 32'h48, 32'h0,        5'd9,  2,  32'h0BADF00D);
    run_instr("ack_last", 2'b11, 2'b10, 32'h4C, 32'h0,        5'd3,  15, 32'h600DD00D);
    run_instr("timeout",  2'b11, 2'b10, 32'h50, 32'h0,        5'd4,  30, 32'h11111111);
    run_instr("late_ack", 2'b11, 2'b10, 32'h54, 32'h0,        5'd6,  16, 32'h22222222);
    run_instr("sticky",   2'b01, 2'b00, 32'h58, 32'h0,        5'd8,  1,  32'h0);

    // Reset in the 2nd BUSY cycle, ack one cycle later.
    WBin = 2'b11; MEMin = 2'b10; ALUin = 32'h80; WNin = 5'd2; mem_rdata = 32'h33333333;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; mem_ack = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
    chk("rstbusy.state", 32'(fsm_state), 32'(ST_IDLE));
    chk("rstbusy.req", 32'(mem_req), 32'h0);
    chk("rstbusy.wben", 32'(wb_enable), 32'h0);
    chk("rstbusy.err", 32'(err), 32'h0);
    @(posedge clk); #1 mem_ack = 1'b0; reset = 1'b1; MEMin = 2'b00;
    @(posedge clk); #1 reset = 1'b0;

    // Randomized instructions.
    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      run_instr($sformatf("rnd%0d", i), 2'($urandom), rop, $urandom & 32'hFFFFFFFC,
                $urandom, 5'($urandom), $urandom_range(1, 17), $urandom);
    end

`ifdef MEM_SUBWORD_EN
    size_v = 2'b00; uns_v = 1'b0;
    run_instr("lb43", 2'b11, 2'b10, 32'h43, 32'h0, 5'd1, 1, 32'h80123456);
    size_v = 2'b01;
    run_instr("lh41", 2'b11, 2'b10, 32'h41, 32'h0, 5'd1, 1, 32'h0);
    size_v = 2'b10;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
